// File: rtl/onehot_req_scheduler_if.sv
// Grant handshake between the request scheduler and its one-hot consumer.
// The master drives the registered one-hot grant; the slave returns ready.
interface onehot_req_scheduler_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] grant_onehot;
    logic         grant_valid;
    logic         grant_ready;

    modport master (
        output grant_onehot,
        output grant_valid,
        input  grant_ready
    );

    modport slave (
        input  grant_onehot,
        input  grant_valid,
        output grant_ready
    );
endinterface

// File: rtl/onehot_req_scheduler.sv
// Captures rising edges on the request lines as pending events and issues them one at a
// time as a registered one-hot grant, with round-robin choice among pending lines.
module onehot_req_scheduler #(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req_in,
    onehot_req_scheduler_if.master    gnt,
    output logic [N-1:0]              pending,
    output logic [$clog2(N+1)-1:0]    pending_cnt,
    output logic [N-1:0]              ovf_flags,
    input  logic                      ovf_clr
);
    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    if (N != 8) begin : g_bad_n
        $error("onehot_req_scheduler: N must be 8");
    end

    logic [N-1:0]  req_q;
    logic [N-1:0]  rise;
    logic [N-1:0]  load_mask;
    logic [N-1:0]  pending_d;
    logic [N-1:0]  ovf_d;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] cand;
    logic          found;
    logic          slot_free;
    logic          load;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign rise      = req_in & ~req_q;
    assign slot_free = ~gnt.grant_valid | gnt.grant_ready;

    // Search registered pending only, upward from ptr with wrap; this cycle's rise waits.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + PW'(i);
            if (!found && pending[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    assign load = slot_free & found;

    always_comb begin
        load_mask = '0;
        if (load) begin
            load_mask[idx] = 1'b1;
        end
    end

    assign pending_d = (pending & ~load_mask) | rise;
    // A rise on a line being loaded this cycle is a fresh event, not an overflow.
    assign ovf_d     = (ovf_clr ? '0 : ovf_flags) | (rise & pending & ~load_mask);

    always_ff @(posedge clk) begin
        req_q <= req_in;
        if (rst) begin
            pending          <= '0;
            pending_cnt      <= '0;
            ovf_flags        <= '0;
            ptr              <= '0;
            gnt.grant_valid  <= 1'b0;
            gnt.grant_onehot <= '0;
        end else begin
            pending     <= pending_d;
            pending_cnt <= popcount(pending_d);
            ovf_flags   <= ovf_d;
            if (slot_free) begin
                gnt.grant_valid  <= load;
                gnt.grant_onehot <= load_mask;
            end
            if (load) begin
                ptr <= idx + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_onehot_req_scheduler.sv
// Directed and randomized checks of onehot_req_scheduler against an event-level model
// that tracks pending lines, the grant slot and the round-robin pointer as plain integers.
module tb_onehot_req_scheduler;
    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] pending;
    logic [3:0] pending_cnt;
    logic [7:0] ovf_flags;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;

    onehot_req_scheduler_if gif ();

    onehot_req_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .gnt         (gif),
        .pending     (pending),
        .pending_cnt (pending_cnt),
        .ovf_flags   (ovf_flags),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit [7:0] m_req_q;
    bit [7:0] m_pend;
    bit [7:0] m_ovf;
    bit       m_gv;
    int       m_gidx;
    int       m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int       loaded;
        bit [7:0] r;
        if (rst) begin
            m_pend  = '0;
            m_ovf   = '0;
            m_gv    = 1'b0;
            m_gidx  = 0;
            m_ptr   = 0;
            m_req_q = req_in;
            return;
        end
        r      = req_in & ~m_req_q;
        loaded = -1;
        if (!m_gv || gif.grant_ready) begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (loaded < 0 && m_pend[j]) loaded = j;
            end
            m_gv = (loaded >= 0);
            if (loaded >= 0) begin
                m_gidx = loaded;
                m_ptr  = (loaded + 1) % 8;
            end
        end
        if (ovf_clr) m_ovf = '0;
        for (int i = 0; i < 8; i++) begin
            if (r[i] && m_pend[i] && i != loaded) m_ovf[i] = 1'b1;
            m_pend[i] = (m_pend[i] && i != loaded) || r[i];
        end
        m_req_q = req_in;
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic tick();
        logic [7:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = m_gv ? 8'(1 << m_gidx) : 8'h00;
        chk("grant_onehot", 32'(gif.grant_onehot), 32'(eg));
        chk("grant_valid", 32'(gif.grant_valid), 32'(m_gv));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("pending_cnt", 32'(pending_cnt), 32'(model_cnt()));
        chk("ovf_flags", 32'(ovf_flags), 32'(m_ovf));
        chk("legal_onehot", 32'($onehot(gif.grant_onehot)), 32'(gif.grant_valid));
    endtask

    logic [7:0] all_seq [8] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

    initial begin
        logic [7:0] flip;
        rst             = 1'b1;
        req_in          = 8'h01;
        gif.grant_ready = 1'b1;
        ovf_clr         = 1'b0;

        // Line held high through reset is not an event
        tick();
        tick();
        chk("rst_valid", 32'(gif.grant_valid), 32'd0);
        chk("rst_cnt", 32'(pending_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_valid", 32'(gif.grant_valid), 32'd0);
            chk("held_pending", 32'(pending), 32'd0);
        end
        req_in = 8'h00;
        tick();

        // Single event on line 5
        req_in = 8'h20;
        tick();
        chk("single_pend", 32'(pending), 32'h20);
        chk("single_nv", 32'(gif.grant_valid), 32'd0);
        req_in = 8'h00;
        tick();
        chk("single_grant", 32'(gif.grant_onehot), 32'h20);
        chk("single_valid", 32'(gif.grant_valid), 32'd1);
        tick();
        chk("single_done", 32'(gif.grant_valid), 32'd0);

        // All eight rise together, ptr = 6
        req_in = 8'hFF;
        tick();
        chk("all_cnt8", 32'(pending_cnt), 32'd8);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("all_grant", 32'(gif.grant_onehot), 32'(all_seq[k]));
            chk("all_cnt", 32'(pending_cnt), 32'(7 - k));
        end
        tick();
        chk("all_done", 32'(gif.grant_valid), 32'd0);
        req_in = 8'h00;
        tick();

        // Backpressure: 04 held while line 1 rises
        gif.grant_ready = 1'b0;
        req_in          = 8'h04;
        tick();
        tick();
        chk("bp_grant", 32'(gif.grant_onehot), 32'h04);
        req_in = 8'h06;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold", 32'(gif.grant_onehot), 32'h04);
            chk("bp_hold_v", 32'(gif.grant_valid), 32'd1);
        end
        chk("bp_pend", 32'(pending), 32'h02);
        gif.grant_ready = 1'b1;
        tick();
        chk("bp_next", 32'(gif.grant_onehot), 32'h02);
        tick();
        chk("bp_done", 32'(gif.grant_valid), 32'd0);

        // Overflow on line 3 while slot stalled on line 0
        gif.grant_ready = 1'b0;
        req_in          = 8'h00;
        tick();
        req_in = 8'h01;
        tick();
        req_in = 8'h09;
        tick();
        chk("ovf_slot", 32'(gif.grant_onehot), 32'h01);
        chk("ovf_pend", 32'(pending), 32'h08);
        req_in = 8'h01;
        tick();
        req_in = 8'h09;
        tick();
        chk("ovf_flag", 32'(ovf_flags), 32'h08);
        chk("ovf_cnt", 32'(pending_cnt), 32'd1);
        ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(ovf_flags), 32'h00);
        ovf_clr = 1'b0;

        // Reset mid-handshake with pending 0C
        req_in = 8'h0D;
        tick();
        chk("mid_pend", 32'(pending), 32'h0C);
        chk("mid_valid", 32'(gif.grant_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", 32'(gif.grant_onehot), 32'h00);
        chk("mid_rst_pend", 32'(pending), 32'h00);
        rst             = 1'b0;
        gif.grant_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_after_v", 32'(gif.grant_valid), 32'd0);
            chk("mid_after_p", 32'(pending), 32'h00);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            flip = '0;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 4) == 0);
            req_in          = req_in ^ flip;
            gif.grant_ready = ($urandom_range(0, 3) != 0);
            ovf_clr         = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
